// File: rtl/pe_reg_pkg.sv
// Shared types and helpers for the PE register bus initiator.
package pe_reg_pkg;

  localparam int unsigned MaxRegs = 256;

  typedef enum logic [1:0] {
    OP_RSVD  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_MOVE  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    TURN = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_e;

  // One-hot decode of idx; indices at or beyond num_regs decode to all zeros.
  function automatic logic [MaxRegs-1:0] onehot(input int unsigned idx, input int unsigned num_regs);
    logic [MaxRegs-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MaxRegs; i++) begin
      v[i] = (i == idx) && (i < num_regs);
    end
    return v;
  endfunction

endpackage

// File: rtl/pe_reg_bus_ctrl.sv
// Bus initiator turning WRITE/READ/MOVE requests into registered CS/WE/OE
// strobes on a shared PE register bus, one response per accepted request.
module pe_reg_bus_ctrl
  import pe_reg_pkg::*;
#(
  parameter int unsigned WordSize = 512,
  parameter int unsigned NumRegs  = 8,
  parameter int unsigned AddrW    = $clog2(NumRegs)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [AddrW-1:0]    req_addr,
  input  logic [AddrW-1:0]    req_dst,
  input  logic [WordSize-1:0] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WordSize-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic [NumRegs-1:0]  CS,
  output logic                WE,
  output logic                OE,
  output logic [WordSize-1:0] BusOut,
  input  logic [WordSize-1:0] BusIn
);

  localparam logic [AddrW:0] NumRegsW = (AddrW + 1)'(NumRegs);

  state_e              state_r;
  state_e              state_s;
  op_e                 op_r;
  op_e                 req_op_s;
  logic [AddrW-1:0]    addr_r;
  logic [AddrW-1:0]    dst_r;
  logic [WordSize-1:0] data_r;

  logic                req_hs_s;
  logic                req_err_s;
  logic [AddrW-1:0]    rd_idx_s;
  logic [AddrW-1:0]    wr_idx_s;
  logic [WordSize-1:0] wr_data_s;

  logic [NumRegs-1:0]  cs_s;
  logic                we_s;
  logic                oe_s;
  logic [WordSize-1:0] bus_s;
  logic                ready_s;
  logic                vld_s;
  logic [WordSize-1:0] rdata_s;
  logic                err_s;

  // Request handshake and legality check.
  always_comb begin
    req_op_s  = op_e'(req_op);
    req_hs_s  = req_valid && req_ready && (state_r == IDLE);
    req_err_s = (req_op_s == OP_RSVD)
             || ({1'b0, req_addr} >= NumRegsW)
             || ((req_op_s == OP_MOVE) && ({1'b0, req_dst} >= NumRegsW));
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!req_hs_s) begin
          state_s = IDLE;
        end else if (req_err_s) begin
          state_s = RESP;
        end else if (req_op_s == OP_WRITE) begin
          state_s = WR;
        end else begin
          state_s = RD;
        end
      end
      RD: begin
        if (op_r == OP_MOVE) begin
          state_s = TURN;
        end else begin
          state_s = RESP;
        end
      end
      TURN:    state_s = WR;
      WR:      state_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Bus operands for the state being entered: fresh request fields when
  // leaving IDLE, latched ones otherwise.
  always_comb begin
    if (state_r == IDLE) begin
      rd_idx_s  = req_addr;
      wr_idx_s  = req_addr;
      wr_data_s = req_wdata;
    end else begin
      rd_idx_s  = addr_r;
      wr_idx_s  = (op_r == OP_MOVE) ? dst_r : addr_r;
      wr_data_s = data_r;
    end
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    cs_s    = '0;
    we_s    = 1'b0;
    oe_s    = 1'b0;
    bus_s   = '0;
    ready_s = 1'b0;
    vld_s   = 1'b0;
    rdata_s = '0;
    err_s   = 1'b0;
    case (state_s)
      IDLE: ready_s = 1'b1;
      RD: begin
        cs_s = NumRegs'(onehot(32'(rd_idx_s), NumRegs));
        oe_s = 1'b1;
      end
      TURN: cs_s = '0;
      WR: begin
        cs_s  = NumRegs'(onehot(32'(wr_idx_s), NumRegs));
        we_s  = 1'b1;
        bus_s = wr_data_s;
      end
      RESP: begin
        vld_s = 1'b1;
        // Read data bypasses data_r because it is captured on this same edge.
        if (state_r == RESP) begin
          rdata_s = rsp_rdata;
          err_s   = rsp_err;
        end else if (state_r == IDLE) begin
          rdata_s = '0;
          err_s   = 1'b1;
        end else if (state_r == RD) begin
          rdata_s = BusIn;
          err_s   = 1'b0;
        end else if (op_r == OP_MOVE) begin
          rdata_s = data_r;
          err_s   = 1'b0;
        end else begin
          rdata_s = '0;
          err_s   = 1'b0;
        end
      end
      default: ready_s = 1'b0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      CS        <= '0;
      WE        <= 1'b0;
      OE        <= 1'b0;
      BusOut    <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_r   <= state_s;
      CS        <= cs_s;
      WE        <= we_s;
      OE        <= oe_s;
      BusOut    <= bus_s;
      req_ready <= ready_s;
      rsp_valid <= vld_s;
      rsp_rdata <= rdata_s;
      rsp_err   <= err_s;
    end
  end

  // Request fields latched on accept; data word replaced by the read capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_r   <= OP_RSVD;
      addr_r <= '0;
      dst_r  <= '0;
      data_r <= '0;
    end else if (req_hs_s) begin
      op_r   <= req_op_s;
      addr_r <= req_addr;
      dst_r  <= req_dst;
      data_r <= req_wdata;
    end else if (state_r == RD) begin
      data_r <= BusIn;
    end
  end

endmodule

// File: tb/tb_pe_reg_bus_ctrl.sv
// Directed bench for pe_reg_bus_ctrl with a behavioural PE register bank
// on the bus and a second NumRegs=6 instance for range checks.
module tb_pe_reg_bus_ctrl;

  localparam int unsigned W  = 512;
  localparam int unsigned N  = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned W6 = 32;

  localparam logic [W-1:0] PAT_A5 = {64{8'hA5}};
  localparam logic [W-1:0] PAT_3C = {64{8'h3C}};
  localparam logic [W-1:0] PAT_77 = {64{8'h77}};

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] req_dst;
  logic [W-1:0]  req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_rdata;
  logic          rsp_err;
  logic [N-1:0]  cs;
  logic          we;
  logic          oe;
  logic [W-1:0]  bus_out;
  logic [W-1:0]  bus_in;

  logic          s6_req_valid;
  logic          s6_req_ready;
  logic [1:0]    s6_req_op;
  logic [2:0]    s6_req_addr;
  logic [2:0]    s6_req_dst;
  logic [W6-1:0] s6_req_wdata;
  logic          s6_rsp_valid;
  logic [W6-1:0] s6_rsp_rdata;
  logic          s6_rsp_err;
  logic [5:0]    s6_cs;
  logic          s6_we;
  logic          s6_oe;
  logic [W6-1:0] s6_bus_out;
  logic [W6-1:0] s6_bus_in;

  logic [W-1:0]  regs [N];
  logic          reg_rst_n;
  logic          mon_en;
  int            total;
  int            bad;

  always #5 clk = ~clk;

  pe_reg_bus_ctrl #(.WordSize(W), .NumRegs(N)) dut (
    .CLK(clk), .RST(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_dst(req_dst), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .CS(cs), .WE(we), .OE(oe), .BusOut(bus_out), .BusIn(bus_in)
  );

  pe_reg_bus_ctrl #(.WordSize(W6), .NumRegs(6)) dut6 (
    .CLK(clk), .RST(rst),
    .req_valid(s6_req_valid), .req_ready(s6_req_ready), .req_op(s6_req_op),
    .req_addr(s6_req_addr), .req_dst(s6_req_dst), .req_wdata(s6_req_wdata),
    .rsp_valid(s6_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(s6_rsp_rdata), .rsp_err(s6_rsp_err),
    .CS(s6_cs), .WE(s6_we), .OE(s6_oe), .BusOut(s6_bus_out), .BusIn(s6_bus_in)
  );

  // PE register bank: write on CS&WE, drive the shared DataOut when CS&OE.
  assign reg_rst_n = !rst;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reg_rst_n && cs[i] && we) regs[i] <= bus_out;
    end
  end
  always_comb begin
    bus_in = '0;
    for (int i = 0; i < N; i++) begin
      if (cs[i] && oe) bus_in = regs[i];
    end
  end

  // Per-cycle bus invariants on both instances.
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if ($countones(cs) > 1 || (we && oe) || (we && $countones(cs) != 1) ||
          (oe && $countones(cs) != 1) || (!we && bus_out != '0)) begin
        bad++;
        $display("FAIL invariant8 t=%0t cs=%b we=%b oe=%b busout_nonzero=%b", $time, cs, we, oe, |bus_out);
      end
      total++;
      if ($countones(s6_cs) > 1 || (s6_we && s6_oe) || (s6_we && $countones(s6_cs) != 1) ||
          (s6_oe && $countones(s6_cs) != 1) || (!s6_we && s6_bus_out != '0)) begin
        bad++;
        $display("FAIL invariant6 t=%0t cs=%b we=%b oe=%b", $time, s6_cs, s6_we, s6_oe);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request on the main instance; returns in cycle N+1 after the accepting edge N.
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] d, input logic [W-1:0] wd);
    int n;
    req_op = op; req_addr = a; req_dst = d; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL accept_timeout got req_ready=%b want 1", req_ready);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic issue6(input logic [1:0] op, input logic [2:0] a, input logic [2:0] d, input logic [W6-1:0] wd);
    int n;
    s6_req_op = op; s6_req_addr = a; s6_req_dst = d; s6_req_wdata = wd; s6_req_valid = 1'b1;
    n = 0;
    while (!s6_req_ready && n < 20) begin
      step();
      n++;
    end
    total++;
    if (!s6_req_ready) begin
      bad++;
      $display("FAIL accept6_timeout got req_ready=%b want 1", s6_req_ready);
    end
    step();
    s6_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    total++;
    if (cs !== 8'h00 || we !== 1'b0 || oe !== 1'b0 || bus_out !== '0) begin
      bad++; $display("FAIL reset_strobes got cs=%h we=%b oe=%b want 0", cs, we, oe);
    end
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL reset_hs got rsp_valid=%b err=%b req_ready=%b want 0", rsp_valid, rsp_err, req_ready);
    end
    rst = 1'b0;
    step();
    total++;
    if (req_ready !== 1'b1 || s6_req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got %b/%b want 1/1", req_ready, s6_req_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_write();
    issue(2'b01, 3'd3, 3'd0, PAT_A5);
    total++;
    if (cs !== 8'b0000_1000 || we !== 1'b1 || oe !== 1'b0 || bus_out !== PAT_A5 || req_ready !== 1'b0) begin
      bad++; $display("FAIL write_strobe got cs=%b we=%b oe=%b rdy=%b want 00001000 1 0 0", cs, we, oe, req_ready);
    end
    step();
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== '0 || cs !== 8'h00) begin
      bad++; $display("FAIL write_rsp got valid=%b err=%b rdata_nz=%b cs=%h want 1 0 0 00", rsp_valid, rsp_err, |rsp_rdata, cs);
    end
    total++;
    if (regs[3] !== PAT_A5) begin
      bad++; $display("FAIL write_reg3 got %h want %h", regs[3][15:0], PAT_A5[15:0]);
    end
    step();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL write_done got valid=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_read();
    issue(2'b10, 3'd3, 3'd0, '0);
    total++;
    if (cs !== 8'b0000_1000 || oe !== 1'b1 || we !== 1'b0 || bus_out !== '0) begin
      bad++; $display("FAIL read_strobe got cs=%b oe=%b we=%b want 00001000 1 0", cs, oe, we);
    end
    step();
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== PAT_A5) begin
      bad++; $display("FAIL read_rsp got valid=%b err=%b rdata=%h want 1 0 a5a5", rsp_valid, rsp_err, rsp_rdata[15:0]);
    end
    step();
  endtask

  task automatic test_move();
    issue(2'b11, 3'd3, 3'd5, '0);
    total++;
    if (cs !== 8'h08 || oe !== 1'b1 || we !== 1'b0) begin
      bad++; $display("FAIL move_rd got cs=%h oe=%b we=%b want 08 1 0", cs, oe, we);
    end
    step();
    total++;
    if (cs !== 8'h00 || oe !== 1'b0 || we !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL move_turn got cs=%h oe=%b we=%b valid=%b want 00 0 0 0", cs, oe, we, rsp_valid);
    end
    step();
    total++;
    if (cs !== 8'h20 || we !== 1'b1 || oe !== 1'b0 || bus_out !== PAT_A5) begin
      bad++; $display("FAIL move_wr got cs=%h we=%b oe=%b bus=%h want 20 1 0 a5a5", cs, we, oe, bus_out[15:0]);
    end
    step();
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== PAT_A5) begin
      bad++; $display("FAIL move_rsp got valid=%b err=%b rdata=%h want 1 0 a5a5", rsp_valid, rsp_err, rsp_rdata[15:0]);
    end
    step();
    issue(2'b10, 3'd5, 3'd0, '0);
    step();
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== PAT_A5) begin
      bad++; $display("FAIL move_readback got valid=%b rdata=%h want 1 a5a5", rsp_valid, rsp_rdata[15:0]);
    end
    step();
    // Source equals destination: read then write back the same word.
    issue(2'b01, 3'd1, 3'd0, PAT_3C);
    step();
    step();
    issue(2'b11, 3'd1, 3'd1, '0);
    step();
    step();
    total++;
    if (cs !== 8'h02 || we !== 1'b1 || bus_out !== PAT_3C) begin
      bad++; $display("FAIL move_self_wr got cs=%h we=%b bus=%h want 02 1 3c3c", cs, we, bus_out[15:0]);
    end
    step();
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== PAT_3C || regs[1] !== PAT_3C) begin
      bad++; $display("FAIL move_self_rsp got valid=%b rdata=%h reg1=%h want 1 3c3c 3c3c", rsp_valid, rsp_rdata[15:0], regs[1][15:0]);
    end
    step();
  endtask

  task automatic test_error();
    issue(2'b00, 3'd2, 3'd0, PAT_77);
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== '0) begin
      bad++; $display("FAIL err_rsvd got valid=%b err=%b rdata_nz=%b want 1 1 0", rsp_valid, rsp_err, |rsp_rdata);
    end
    total++;
    if (cs !== 8'h00 || we !== 1'b0 || oe !== 1'b0) begin
      bad++; $display("FAIL err_rsvd_bus got cs=%h we=%b oe=%b want 00 0 0", cs, we, oe);
    end
    step();
    total++;
    if (rsp_valid !== 1'b0 || cs !== 8'h00 || regs[2] === PAT_77) begin
      bad++; $display("FAIL err_rsvd_done got valid=%b cs=%h want 0 00", rsp_valid, cs);
    end
  endtask

  task automatic test_nonpow2();
    issue6(2'b10, 3'd7, 3'd0, '0);
    total++;
    if (s6_rsp_valid !== 1'b1 || s6_rsp_err !== 1'b1 || s6_rsp_rdata !== '0 || s6_cs !== 6'd0 || s6_oe !== 1'b0) begin
      bad++; $display("FAIL n6_read7 got valid=%b err=%b cs=%b oe=%b want 1 1 000000 0", s6_rsp_valid, s6_rsp_err, s6_cs, s6_oe);
    end
    step();
    issue6(2'b11, 3'd2, 3'd6, '0);
    total++;
    if (s6_rsp_valid !== 1'b1 || s6_rsp_err !== 1'b1 || s6_cs !== 6'd0) begin
      bad++; $display("FAIL n6_move_dst6 got valid=%b err=%b cs=%b want 1 1 000000", s6_rsp_valid, s6_rsp_err, s6_cs);
    end
    step();
    issue6(2'b01, 3'd5, 3'd0, 32'hDEAD_BEEF);
    total++;
    if (s6_cs !== 6'b10_0000 || s6_we !== 1'b1 || s6_bus_out !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL n6_write5 got cs=%b we=%b bus=%h want 100000 1 deadbeef", s6_cs, s6_we, s6_bus_out);
    end
    step();
    total++;
    if (s6_rsp_valid !== 1'b1 || s6_rsp_err !== 1'b0) begin
      bad++; $display("FAIL n6_write5_rsp got valid=%b err=%b want 1 0", s6_rsp_valid, s6_rsp_err);
    end
    step();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    issue(2'b10, 3'd3, 3'd0, '0);
    step();
    req_op = 2'b01; req_addr = 3'd3; req_dst = 3'd0; req_wdata = PAT_77; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== PAT_A5 || rsp_err !== 1'b0 || req_ready !== 1'b0 || cs !== 8'h00) begin
        bad++; $display("FAIL hold%0d got valid=%b rdata=%h err=%b rdy=%b cs=%h want 1 a5a5 0 0 00",
                        i, rsp_valid, rsp_rdata[15:0], rsp_err, req_ready, cs);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || cs !== 8'h00 || regs[3] !== PAT_A5) begin
      bad++; $display("FAIL hold_release got valid=%b rdy=%b cs=%h want 0 1 00", rsp_valid, req_ready, cs);
    end
    step();
    req_valid = 1'b0;
    total++;
    if (cs !== 8'h08 || we !== 1'b1 || bus_out !== PAT_77) begin
      bad++; $display("FAIL hold_next_accept got cs=%h we=%b bus=%h want 08 1 7777", cs, we, bus_out[15:0]);
    end
    step();
    step();
  endtask

  task automatic test_reset_mid();
    issue(2'b11, 3'd3, 3'd5, '0);
    step();
    rst = 1'b1;
    step();
    total++;
    if (cs !== 8'h00 || we !== 1'b0 || oe !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL rstmid_strobes got cs=%h we=%b oe=%b valid=%b rdy=%b want all 0", cs, we, oe, rsp_valid, req_ready);
    end
    rst = 1'b0;
    step();
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_idle got rdy=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rsp_valid !== 1'b0 || cs !== 8'h00) begin
        bad++; $display("FAIL rstmid_quiet%0d got valid=%b cs=%h want 0 00", i, rsp_valid, cs);
      end
      step();
    end
    total++;
    if (regs[5] !== PAT_A5) begin
      bad++; $display("FAIL rstmid_dst got %h want a5a5", regs[5][15:0]);
    end
    issue(2'b10, 3'd5, 3'd0, '0);
    step();
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== PAT_A5) begin
      bad++; $display("FAIL rstmid_readback got valid=%b rdata=%h want 1 a5a5", rsp_valid, rsp_rdata[15:0]);
    end
    step();
  endtask

  initial begin
    total = 0; bad = 0; mon_en = 1'b0;
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_dst = '0; req_wdata = '0;
    s6_req_valid = 1'b0; s6_req_op = 2'b00; s6_req_addr = '0; s6_req_dst = '0; s6_req_wdata = '0;
    s6_bus_in = '0;
    #1;
    test_reset();
    test_write();
    test_read();
    test_move();
    test_error();
    test_nonpow2();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pe_reg_bus_ctrl.md
Name: pe_reg_bus_ctrl

Overview:
Bus initiator for a bank of PE connection registers, each with CS/WE/OE control, a DataIn bus and a tri-stated DataOut bus. It accepts WRITE, READ and MOVE (register-to-register copy) requests on a valid/ready interface and turns each request into correctly timed CS/WE/OE strobes. It returns exactly one response per accepted request on a second valid/ready interface. It sits between the vector sequencer and the PE register bank.

Parameters:
WordSize, 512, data word width in bits
NumRegs, 8, number of registers on the bus (2 or more; need not be a power of two)
AddrW, $clog2(NumRegs), register index width

Ports:
CLK  input  1  clock; all logic on posedge
RST  input  1  synchronous active-high reset
req_valid  input  1  request valid
req_ready  output  1  request accepted when valid && ready
req_op  input  2  00 reserved, 01 WRITE, 10 READ, 11 MOVE
req_addr  input  AddrW  target register (WRITE/READ) or source register (MOVE)
req_dst  input  AddrW  destination register (MOVE only)
req_wdata  input  WordSize  write data (WRITE only)
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when valid && ready
rsp_rdata  output  WordSize  read or moved data; 0 for WRITE and for errors
rsp_err  output  1  request was rejected
CS  output  NumRegs  one-hot chip select, one bit per register
WE  output  1  write enable, shared by all registers
OE  output  1  output enable, shared by all registers
BusOut  output  WordSize  drives the DataIn of every register
BusIn  input  WordSize  resolved tri-state DataOut bus

Behaviour:
- Reset (RST high at posedge): state goes to IDLE. CS=0, WE=0, OE=0, BusOut=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
- Reset mid-operation: any in-flight transaction is dropped and produces no response. Strobes are 0 from the next cycle.
- All bus outputs are registered (Moore, decoded from state). The block never drives CS, WE and OE combinationally from req_*.
- States: IDLE, RD, TURN, WR, RESP.
- IDLE: req_ready=1 and all strobes 0. On handshake, latch op, addr, dst and wdata.
  - WRITE goes to WR.
  - READ goes to RD.
  - MOVE goes to RD.
  - Error goes to RESP with err=1 and no bus activity. Error means op==00, or addr>=NumRegs, or (MOVE and dst>=NumRegs).
- RD: CS[addr]=1, OE=1, WE=0 for exactly one cycle. BusIn is captured into the data register at the end of that cycle. Next state is TURN for MOVE, otherwise RESP.
- TURN: one idle cycle with CS=0 and OE=0, giving bus turnaround before the write. Next state is WR.
- WR: CS[target]=1, WE=1, OE=0, BusOut=data for exactly one cycle.
  - target is addr for WRITE and dst for MOVE.
  - data is wdata for WRITE and the captured value for MOVE.
  - Next state is RESP.
- RESP: rsp_valid=1 with rdata and err held stable until rsp_ready. On handshake, go to IDLE; rsp_valid drops the next cycle.
- req_ready=0 outside IDLE. No pipelining, and no direct RESP-to-accept transition.
- Latency (request accepted at edge N):
  - WRITE: strobes during cycle N+1; rsp_valid from cycle N+2.
  - READ: strobes during cycle N+1; rsp_valid from cycle N+2.
  - MOVE: RD in N+1, TURN in N+2, WR in N+3, rsp_valid from N+4.
  - Error: rsp_valid from N+1.
- Invariants, all required every cycle:
  - popcount(CS) <= 1.
  - WE && OE is never true.
  - WE implies exactly one CS bit is set.
  - OE implies exactly one CS bit is set.
  - BusOut=0 whenever WE=0.
- MOVE with src==dst is legal: it reads, then writes back the same value.
- rsp_rdata for WRITE is 0. For MOVE it is the moved word.

Decomposition:
- Shared package pe_reg_pkg holds:
  - op_e enum {OP_RSVD, OP_WRITE, OP_READ, OP_MOVE}
  - state_e enum {IDLE, RD, TURN, WR, RESP}
  - a one-hot decode function onehot(idx, NumRegs)
- No sub-module is needed. The bench instantiates NumRegs copies of the existing PE register model on CS/WE/OE, BusOut and BusIn, with its reset tied to !RST.

Test Plan:
- WRITE addr=3, wdata=0xA5 repeated to 512 bits -> cycle N+1 has CS=8'b0000_1000 and WE=1; rsp_valid at N+2 with err=0 and rdata=0; register 3 holds 0xA5 pattern.
- READ addr=3 after the above -> cycle N+1 has CS[3]=1 and OE=1; rsp_rdata = 0xA5 pattern at N+2.
- MOVE addr=3, dst=5 -> RD on CS[3], one TURN cycle with CS=0, WR on CS[5] with the 0xA5 pattern; rsp at N+4; a subsequent READ of 5 returns 0xA5.
- op=00, and separately (NumRegs=6) READ addr=7 -> rsp_err=1 at N+1, rdata=0, CS/WE/OE stay 0 throughout.
- Hold rsp_ready=0 for 5 cycles after a READ -> rsp_valid, rdata and err are stable; req_ready=0; a new req_valid is not accepted until the cycle after the response handshake.
- Assert RST during the TURN cycle of a MOVE -> next cycle all strobes are 0; no response is produced; dst register is unchanged; IDLE with req_ready=1 after RST drops.
